// File: rtl/inv_cipher_if.sv
// Block-side bus of the iterative AES inverse cipher: ciphertext in, plaintext out,
// plus the registered read port of the external expanded-key RAM.
interface inv_cipher_if;
    // A transfer happens on a rising clk edge where valid && ready are both high; a source
    // holds valid and its data stable until that edge, and ready may depend on the sink state.
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    modport slave (
        input  in_valid, ciphertext, key_data, out_ready,
        output in_ready, key_addr, out_valid, plaintext
    );

    modport master (
        output in_valid, ciphertext, key_data, out_ready,
        input  in_ready, key_addr, out_valid, plaintext
    );
endinterface

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys read NR..0 from an
// external expanded-key RAM whose data arrives one cycle after the address.
module inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst,
    inv_cipher_if.slave      bus,
    output logic [1:0]       o_dbg_state
);
    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("inv_cipher_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ROUND, S_DONE} state_t;

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] isb(input logic [7:0] b);
        return INV_SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{k[0]}} & b) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    // Byte 4c+r is state[r][c]; row r rotates right by r columns, then each byte is inverted.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = isb(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [3:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   acc;
        logic [127:0] o;
        cf = '{4'he, 4'hb, 4'hd, 4'h9};
        o  = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc ^= gmul(a[j], cf[(j - r + 4) % 4]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_blk;
    logic [127:0]   r_pt;
    logic [3:0]     r_cnt;
    logic [3:0]     r_key_addr;
    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_accept;
    logic [127:0]   w_isr_isb;
    logic [127:0]   w_ark;
    logic [127:0]   w_imc;

    assign w_isr_isb = inv_shift_sub(r_blk);
    assign w_ark     = w_isr_isb ^ bus.key_data;
    assign w_imc     = inv_mix(w_ark);
    assign w_accept  = bus.in_valid && w_in_ready;

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_FETCH;
            end
            S_FETCH: w_next = S_ROUND;
            S_ROUND: if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE: begin
                // Result hand-off and next acceptance share the cycle for full throughput.
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
                if (bus.out_ready) w_next = bus.in_valid ? S_FETCH : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk      <= '0;
            r_pt       <= '0;
            r_cnt      <= '0;
            r_key_addr <= '0;
        end else if (w_accept) begin
            r_blk      <= bus.ciphertext;
            r_key_addr <= NR_L;
            r_cnt      <= NR_L;
        end else if (r_state == S_FETCH) begin
            r_key_addr <= NR_M1;
        end else if (r_state == S_ROUND) begin
            if (r_cnt == NR_L)       r_blk <= r_blk ^ bus.key_data;
            else if (r_cnt != 4'd0)  r_blk <= w_imc;
            else                     r_pt  <= w_ark;
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            // Address runs two ahead of the counter to cover the RAM read latency.
            r_key_addr <= (r_cnt >= 4'd2) ? (r_cnt - 4'd2) : 4'd0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.key_addr  = r_key_addr;
    assign bus.plaintext = r_pt;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: NR=10 and NR=14 instances, key RAMs filled by a key-expansion
// model, expected plaintexts from FIPS-197 vectors and a forward-cipher model.
module tb_inv_cipher_iter;
    localparam logic [127:0] B1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_cipher_if bus10 ();
    inv_cipher_if bus14 ();
    logic [1:0] dbg10, dbg14;

    inv_cipher_iter #(.NR(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10.slave), .o_dbg_state(dbg10));
    inv_cipher_iter #(.NR(14)) dut14 (.clk(clk), .rst(rst), .bus(bus14.slave), .o_dbg_state(dbg14));

    logic [127:0] ram10 [0:10];
    logic [127:0] ram14 [0:14];
    always @(posedge clk) bus10.key_data <= (bus10.key_addr <= 4'd10) ? ram10[bus10.key_addr] : '0;
    always @(posedge clk) bus14.key_data <= (bus14.key_addr <= 4'd14) ? ram14[bus14.key_addr] : '0;

    // ---------------- scoreboard state ----------------
    logic [127:0] exp10_q[$];
    logic [127:0] exp14_q[$];
    int           lat10_q[$];
    int           lat14_q[$];
    bit           seen10 = 0, seen14 = 0;
    int           n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, why);
    endtask

    // ---------------- reference model (forward direction) ----------------
    logic [7:0]   fsb [256];
    logic [127:0] ek  [0:14];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = fsb[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [7:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   acc;
        logic [127:0] o;
        cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc ^= gm(a[j], cf[(j - r + 4) % 4]);
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ ek[0];
        for (int r = 1; r < nr; r++) s = mix(sub_shift(s)) ^ ek[r];
        return sub_shift(s) ^ ek[nr];
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_w(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 15; j++)
            ek[j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
    endtask

    task automatic load10(input logic [127:0] key);
        expand({key, 128'h0}, 4, 10);
        for (int j = 0; j <= 10; j++) ram10[j] = ek[j];
    endtask

    task automatic load14(input logic [255:0] key);
        expand(key, 8, 14);
        for (int j = 0; j <= 14; j++) ram14[j] = ek[j];
    endtask

    // ---------------- drivers ----------------
    task automatic send10(input logic [127:0] ct, input logic [127:0] pt, output int t_acc);
        int n;
        @(negedge clk);
        bus10.in_valid   = 1'b1;
        bus10.ciphertext = ct;
        #1;
        n = 0;
        while (!bus10.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept10", 128'(bus10.in_ready), 128'h1);
        t_acc = cyc;
        exp10_q.push_back(pt);
        lat10_q.push_back(cyc);
        @(posedge clk);
        #1;
        bus10.in_valid = 1'b0;
    endtask

    task automatic send14(input logic [127:0] ct, input logic [127:0] pt, output int t_acc);
        int n;
        @(negedge clk);
        bus14.in_valid   = 1'b1;
        bus14.ciphertext = ct;
        #1;
        n = 0;
        while (!bus14.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept14", 128'(bus14.in_ready), 128'h1);
        t_acc = cyc;
        exp14_q.push_back(pt);
        lat14_q.push_back(cyc);
        @(posedge clk);
        #1;
        bus14.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp10_q.size() != 0 || exp14_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 128'(exp10_q.size() + exp14_q.size()), 128'h0);
        exp10_q.delete();
        exp14_q.delete();
        lat10_q.delete();
        lat14_q.delete();
    endtask

    // ---------------- monitors ----------------
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            n_cmp++;
            if (bus10.key_addr > 4'd10) begin
                n_err++;
                $display("FAIL kaddr10_range: got %0d, required <= 10", bus10.key_addr);
            end
            if (bus10.out_valid && !seen10) begin
                seen10 = 1;
                if (lat10_q.size() == 0) fail_now("lat10", "out_valid with no block in flight");
                else chk("lat10", 128'(cyc - lat10_q.pop_front()), 128'd13);
            end
            if (bus10.out_valid && bus10.out_ready) begin
                seen10 = 0;
                if (exp10_q.size() == 0) fail_now("pt10", "result with empty expected queue");
                else chk("pt10", bus10.plaintext, exp10_q.pop_front());
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            n_cmp++;
            if (bus14.key_addr > 4'd14) begin
                n_err++;
                $display("FAIL kaddr14_range: got %0d, required <= 14", bus14.key_addr);
            end
            if (bus14.out_valid && !seen14) begin
                seen14 = 1;
                if (lat14_q.size() == 0) fail_now("lat14", "out_valid with no block in flight");
                else chk("lat14", 128'(cyc - lat14_q.pop_front()), 128'd17);
            end
            if (bus14.out_valid && bus14.out_ready) begin
                seen14 = 0;
                if (exp14_q.size() == 0) fail_now("pt14", "result with empty expected queue");
                else chk("pt14", bus14.plaintext, exp14_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- test sequence ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t         tbl [6];
    int           t_a, t_b, n;
    logic [127:0] k_r, p_r;
    logic [7:0]   inv;

    initial begin
        rst              = 1'b1;
        bus10.in_valid   = 1'b0;
        bus10.ciphertext = '0;
        bus10.out_ready  = 1'b1;
        bus14.in_valid   = 1'b0;
        bus14.ciphertext = '0;
        bus14.out_ready  = 1'b1;

        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fsb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end

        tbl[0] = '{key: B1_KEY, ct: B1_CT, pt: B1_PT};
        tbl[1] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
        for (int i = 2; i < 6; i++) begin
            k_r = {$urandom(), $urandom(), $urandom(), $urandom()};
            p_r = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand({k_r, 128'h0}, 4, 10);
            tbl[i] = '{key: k_r, ct: encrypt(p_r, 10), pt: p_r};
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 128'(bus10.in_ready), 128'h1);
        chk("rst_out_valid", 128'(bus10.out_valid), 128'h0);
        chk("rst_key_addr", 128'(bus10.key_addr), 128'h0);
        chk("rst_plaintext", bus10.plaintext, 128'h0);
        chk("rst_state", 128'(dbg10), 128'h0);
        #2 rst = 1'b0;

        load10(C1_KEY);
        chk("model_c1_rk10", ram10[10], C1_RK10);
        load10(B1_KEY);
        chk("model_b1_encrypt", encrypt(B1_PT, 10), B1_CT);

        // Table of vectors, one block at a time
        for (int i = 0; i < 6; i++) begin
            load10(tbl[i].key);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send10(tbl[i].ct, tbl[i].pt, t_a);
            if (i == 1) begin
                for (int k = 0; k <= 10; k++) begin
                    @(negedge clk);
                    #1;
                    chk("c1_kaddr_seq", 128'(bus10.key_addr), 128'(10 - k));
                end
            end
            drain();
        end

        // Back-to-back B.1 then C.1; the key RAM is swapped while B.1 sits in DONE
        load10(B1_KEY);
        send10(B1_CT, B1_PT, t_a);
        fork
            send10(C1_CT, C1_PT, t_b);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    #1;
                    n++;
                end while (!bus10.out_valid && n < 50);
                load10(C1_KEY);
            end
        join
        chk("b2b_accept_gap", 128'(t_b - t_a), 128'd13);
        drain();

        // Backpressure: result held for 5 cycles
        load10(B1_KEY);
        bus10.out_ready = 1'b0;
        send10(B1_CT, B1_PT, t_a);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus10.out_valid && n < 50);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 128'(bus10.out_valid), 128'h1);
            chk("hold_plaintext", bus10.plaintext, B1_PT);
            chk("hold_in_ready", 128'(bus10.in_ready), 128'h0);
            @(negedge clk);
            #1;
        end
        bus10.out_ready = 1'b1;
        drain();

        // NR=14: C.3 and a model-generated block
        load14(C3_KEY);
        send14(C3_CT, C1_PT, t_a);
        drain();
        k_r = {$urandom(), $urandom(), $urandom(), $urandom()};
        p_r = {$urandom(), $urandom(), $urandom(), $urandom()};
        load14({k_r, ~k_r});
        send14(encrypt(p_r, 14), p_r, t_a);
        drain();

        // Asynchronous reset in round 5, then a clean block
        load10(C1_KEY);
        send10(C1_CT, C1_PT, t_a);
        repeat (7) @(negedge clk);
        #3;
        chk("midrst_pre_state", 128'(dbg10), 128'd2);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(bus10.out_valid), 128'h0);
        chk("midrst_key_addr", 128'(bus10.key_addr), 128'h0);
        chk("midrst_in_ready", 128'(bus10.in_ready), 128'h1);
        chk("midrst_state", 128'(dbg10), 128'h0);
        exp10_q.delete();
        lat10_q.delete();
        seen10 = 0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        load10(B1_KEY);
        send10(B1_CT, B1_PT, t_a);
        drain();

        // Stall while busy: second block offered throughout the first block's rounds
        load10(B1_KEY);
        p_r = {$urandom(), $urandom(), $urandom(), $urandom()};
        send10(B1_CT, B1_PT, t_a);
        @(negedge clk);
        bus10.in_valid   = 1'b1;
        bus10.ciphertext = encrypt(p_r, 10);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_in_ready", 128'(bus10.in_ready), 128'h0);
            @(negedge clk);
        end
        send10(encrypt(p_r, 10), p_r, t_b);
        chk("stall_accept_gap", 128'(t_b - t_a), 128'd13);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
